// File: rtl/counter_pkg.sv
// Shared counter types and helpers.
// Provides the count direction enum and binary-to-Gray conversion.
package counter_pkg;

  typedef enum logic {
    DN = 1'b0,
    UP = 1'b1
  } count_dir_e;

  // Operates on 32 bits; callers cast to and from their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter for health monitors.
// Ports: clk, rst (async high), inc, clr (sync), cnt (W bits).
module sat_event_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // A clear in the same cycle as an event leaves a count of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= W'(inc);
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/self_correcting_mod_counter.sv
// Modulo up/down counter with Gray copy and illegal-state recovery.
// Ports: clk, rst, enable, up_dn, load, load_value, clear_err in;
//        count, gray_count, tc, corrected, load_err, err_sticky,
//        corr_cnt out.
module self_correcting_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int MODULUS        = 10,
  parameter int RECOVERY_VALUE = 0,
  parameter int CORR_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      count,
  output logic [WIDTH-1:0]      gray_count,
  output logic                  tc,
  output logic                  corrected,
  output logic                  load_err,
  output logic                  err_sticky,
  output logic [CORR_CNT_W-1:0] corr_cnt
);

  if (WIDTH < 2 || WIDTH > 31) begin : g_chk_width
    $error("WIDTH out of range");
  end
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_chk_mod
    $error("MODULUS out of range");
  end
  if (RECOVERY_VALUE < 0 || RECOVERY_VALUE >= MODULUS) begin : g_chk_rec
    $error("RECOVERY_VALUE must be below MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] REC_V = WIDTH'(RECOVERY_VALUE);
  // One extra bit so MODULUS == 2**WIDTH is representable and
  // the range check folds to constant false.
  localparam logic [WIDTH:0]   MOD_V = (WIDTH + 1)'(MODULUS);

  count_dir_e       dir;
  logic             range_err;
  logic             gray_err;
  logic             illegal;
  logic             load_ok;
  logic [WIDTH-1:0] count_nxt;
  logic             corr_nxt;
  logic             lerr_nxt;

  assign dir       = count_dir_e'(up_dn);
  assign range_err = ({1'b0, count} >= MOD_V);
  assign gray_err  = bin2gray(32'(count)) != 32'(gray_count);
  assign illegal   = range_err | gray_err;
  assign load_ok   = ({1'b0, load_value} < MOD_V);

  assign tc = enable & ~illegal &
              ((dir == UP) ? (count == MAX_V) : (count == '0));

  // Overlapping conditions resolve top-down.
  always_comb begin
    count_nxt = count;
    corr_nxt  = 1'b0;
    lerr_nxt  = 1'b0;
    priority case (1'b1)
      illegal: begin
        count_nxt = REC_V;
        corr_nxt  = 1'b1;
      end
      load: begin
        if (load_ok) begin
          count_nxt = load_value;
        end else begin
          count_nxt = REC_V;
          lerr_nxt  = 1'b1;
        end
      end
      enable: begin
        if (dir == UP) begin
          count_nxt = (count == MAX_V) ? '0 : count + 1'b1;
        end else begin
          count_nxt = (count == '0) ? MAX_V : count - 1'b1;
        end
      end
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      gray_count <= '0;
      corrected  <= 1'b0;
      load_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      count      <= count_nxt;
      gray_count <= WIDTH'(bin2gray(32'(count_nxt)));
      corrected  <= corr_nxt;
      load_err   <= lerr_nxt;
      if (corr_nxt || lerr_nxt) begin
        err_sticky <= 1'b1;
      end else if (clear_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

  sat_event_counter #(
    .W(CORR_CNT_W)
  ) u_corr_cnt (
    .clk(clk),
    .rst(rst),
    .inc(corr_nxt),
    .clr(clear_err),
    .cnt(corr_cnt)
  );

endmodule

// File: tb/tb_self_correcting_mod_counter.sv
// Self-checking bench for self_correcting_mod_counter.
// Behavioural model plus directed and random stimulus.
module tb_self_correcting_mod_counter;

  localparam int W  = 4;
  localparam int M  = 10;
  localparam int RV = 0;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          up_dn = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_value = '0;
  logic          clear_err = 1'b0;
  logic [W-1:0]  count;
  logic [W-1:0]  gray_count;
  logic          tc;
  logic          corrected;
  logic          load_err;
  logic          err_sticky;
  logic [CW-1:0] corr_cnt;

  self_correcting_mod_counter #(
    .WIDTH(W),
    .MODULUS(M),
    .RECOVERY_VALUE(RV),
    .CORR_CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .up_dn(up_dn),
    .load(load),
    .load_value(load_value),
    .clear_err(clear_err),
    .count(count),
    .gray_count(gray_count),
    .tc(tc),
    .corrected(corrected),
    .load_err(load_err),
    .err_sticky(err_sticky),
    .corr_cnt(corr_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int m_count  = 0;
  int m_corr   = 0;
  int m_lerr   = 0;
  int m_sticky = 0;
  int m_cc     = 0;
  bit inj      = 1'b0;
  logic [W-1:0] force_val = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Reference model: state updates from the rules as integers.
  always @(posedge clk or posedge rst) begin
    int ev_c;
    int ev_l;
    if (rst) begin
      m_count = 0; m_corr = 0; m_lerr = 0;
      m_sticky = 0; m_cc = 0;
    end else begin
      ev_c = inj ? 1 : 0;
      ev_l = 0;
      if (inj) m_count = RV;
      else if (load) begin
        if (int'(load_value) < M) m_count = int'(load_value);
        else begin m_count = RV; ev_l = 1; end
      end else if (enable) begin
        if (up_dn) m_count = (m_count + 1) % M;
        else m_count = (m_count + M - 1) % M;
      end
      m_corr = ev_c;
      m_lerr = ev_l;
      if (ev_c != 0 || ev_l != 0) m_sticky = 1;
      else if (clear_err) m_sticky = 0;
      if (clear_err) m_cc = ev_c;
      else if (ev_c != 0 && m_cc < CMAX) m_cc++;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    int exp_tc;
    exp_tc = (enable && !inj &&
              (up_dn ? (m_count == M - 1) : (m_count == 0))) ? 1 : 0;
    chk("count", int'(count), m_count);
    chk("gray_count", int'(gray_count), gray_of(m_count));
    chk("tc", int'(tc), exp_tc);
    chk("corrected", int'(corrected), m_corr);
    chk("load_err", int'(load_err), m_lerr);
    chk("err_sticky", int'(err_sticky), m_sticky);
    chk("corr_cnt", int'(corr_cnt), m_cc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Corrupt count or gray_count just before an edge, then let go.
  task automatic inject(input bit gray_kind, input logic [W-1:0] val);
    @(negedge clk);
    #1;
    inj = 1'b1;
    force_val = val;
    if (gray_kind) force dut.gray_count = force_val;
    else force dut.count = force_val;
    #1 chk("tc_illegal", int'(tc), 0);
    #1;
    if (gray_kind) release dut.gray_count;
    else release dut.count;
    @(posedge clk);
    #1;
    inj = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ticks(2);
    chk("rst_count", int'(count), 0);
    chk("rst_cc", int'(corr_cnt), 0);
    rst = 1'b0;

    enable = 1'b1; up_dn = 1'b1;
    ticks(7);
    chk("lit_count7", int'(count), 7);
    chk("lit_gray7", int'(gray_count), 4);
    ticks(5);
    chk("lit_wrap", int'(count), 2);

    load = 1'b1; load_value = 4'd0;
    tick();
    load = 1'b0; up_dn = 1'b0;
    tick();
    chk("lit_down_wrap", int'(count), 9);
    tick();
    chk("lit_down8", int'(count), 8);
    enable = 1'b0;
    ticks(5);
    chk("lit_hold", int'(count), 8);

    enable = 1'b1; up_dn = 1'b1; load = 1'b1; load_value = 4'd5;
    inject(1'b0, 4'd13);
    chk("lit_rec_count", int'(count), 0);
    chk("lit_rec_corr", int'(corrected), 1);
    chk("lit_rec_cc", int'(corr_cnt), 1);
    load_value = 4'd9;
    tick();
    load = 1'b0;
    inject(1'b1, 4'b1111);
    chk("lit_gray_rec", int'(count), 0);
    chk("lit_gray_cc", int'(corr_cnt), 2);

    load = 1'b1; load_value = 4'd12;
    tick();
    load = 1'b0; enable = 1'b0;
    chk("lit_lerr", int'(load_err), 1);
    chk("lit_lerr_cc", int'(corr_cnt), 2);
    clear_err = 1'b1;
    tick();
    chk("lit_clr_sticky", int'(err_sticky), 0);
    chk("lit_clr_cc", int'(corr_cnt), 0);
    inject(1'b0, 4'd11);
    chk("lit_clr_set_sticky", int'(err_sticky), 1);
    chk("lit_clr_set_cc", int'(corr_cnt), 1);
    clear_err = 1'b0;

    for (int i = 0; i < 5; i++) inject(1'b0, 4'd15);
    chk("lit_sat", int'(corr_cnt), 3);

    enable = 1'b1;
    ticks(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_gray", int'(gray_count), 0);
    chk("arst_sticky", int'(err_sticky), 0);
    chk("arst_cc", int'(corr_cnt), 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      enable     = ($urandom_range(0, 3) != 0);
      up_dn      = $urandom_range(0, 1) == 1;
      load       = ($urandom_range(0, 7) == 0);
      load_value = W'($urandom_range(0, 15));
      clear_err  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 1)
          inject(1'b0, W'($urandom_range(M, 15)));
        else
          inject(1'b1, ~W'(gray_of(m_count)));
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
